// File: rtl/downsamp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : downsamp_ctrl
// Purpose  : Runtime-ratio decimation controller. Keeps the first sample of
//            every group of R valid input samples, buffers kept samples in a
//            4-entry FIFO and presents them on the dsoutdata/out_en/outbusy
//            handshake. A sticky overflow flag reports dropped samples.
// Ports    : clk, rst        - system clock, synchronous active-high reset
//            enable          - 1 = RUN, 0 = IDLE
//            dataIn/in_valid - input sample stream
//            ratio/ratio_load- pending decimation ratio load (0 acts as 1)
//            dsoutdata       - FIFO head (last popped value when empty)
//            out_en          - transfer this cycle (non-empty and not busy)
//            outbusy         - consumer back-pressure, acts same cycle
//            overflow        - sticky drop flag, cleared by ratio_load
// Revision : 1.0 - initial release
// ============================================================================
module downsamp_ctrl #(
    parameter int DATA_WIDTH  = 14,
    parameter int RATIO_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] dataIn,
    input  logic                         in_valid,
    input  logic [RATIO_WIDTH-1:0]       ratio,
    input  logic                         ratio_load,
    output logic signed [DATA_WIDTH-1:0] dsoutdata,
    output logic                         out_en,
    input  logic                         outbusy,
    output logic                         overflow
);

    localparam logic [RATIO_WIDTH-1:0] c_RATIO_ONE = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RATIO_WIDTH-1:0] c_RATIO_ZERO = '0;
    localparam logic [2:0]             c_FIFO_FULL = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [RATIO_WIDTH-1:0]       r_active_ratio;
    logic [RATIO_WIDTH-1:0]       r_pending_ratio;
    logic [RATIO_WIDTH-1:0]       r_phase;
    logic [2:0]                   r_count;
    logic [1:0]                   r_wr_ptr;
    logic [1:0]                   r_rd_ptr;
    logic signed [DATA_WIDTH-1:0] r_mem [0:3];
    logic signed [DATA_WIDTH-1:0] r_last;
    logic                         r_overflow;

    logic                         w_run;
    logic [RATIO_WIDTH-1:0]       w_ratio_sat;
    logic [RATIO_WIDTH-1:0]       w_last_phase;
    logic                         w_boundary;
    logic                         w_keep;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_drop;

    // ------------------------------------------------------------------
    // State machine: the registered state, not the live enable, gates
    // pushes, so a sample arriving on the cycle enable falls is still
    // handled by whatever state was latched on the previous edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (enable) begin
            w_state_nxt = ST_RUN;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_run        = (r_state == ST_RUN);
    assign w_ratio_sat  = (ratio == c_RATIO_ZERO) ? c_RATIO_ONE : ratio;
    assign w_last_phase = r_active_ratio - c_RATIO_ONE;
    assign w_boundary   = w_run && in_valid && (r_phase == w_last_phase);
    assign w_keep       = w_run && in_valid && (r_phase == c_RATIO_ZERO);

    // Pop frees a slot in the same cycle, so a push into a full FIFO is
    // only a drop when no pop happens alongside it.
    assign w_pop  = out_en;
    assign w_push = w_keep && ((r_count != c_FIFO_FULL) || w_pop);
    assign w_drop = w_keep && (r_count == c_FIFO_FULL) && !w_pop;

    // ------------------------------------------------------------------
    // Ratio registers and phase counter. The active ratio only changes at
    // a group boundary (or while idle) so a group is never split.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_ratio  <= c_RATIO_ONE;
            r_pending_ratio <= c_RATIO_ONE;
            r_phase         <= c_RATIO_ZERO;
        end else begin
            if (ratio_load) begin
                r_pending_ratio <= w_ratio_sat;
            end
            if (!w_run || w_boundary) begin
                r_active_ratio <= r_pending_ratio;
            end
            if (!w_run) begin
                r_phase <= c_RATIO_ZERO;
            end else if (in_valid) begin
                r_phase <= w_boundary ? c_RATIO_ZERO : (r_phase + c_RATIO_ONE);
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 3'd0;
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: a slot is never read before it is written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dataIn;
        end
    end

    // Sticky drop flag; a ratio load in the same cycle as a drop wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (ratio_load) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign out_en    = (r_count != 3'd0) && !outbusy;
    // When empty, show the most recently transferred sample rather than a
    // stale slot of the storage array.
    assign dsoutdata = (r_count != 3'd0) ? r_mem[r_rd_ptr] : r_last;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
